// File: rtl/enigma_stream_ctrl.sv
// Byte-stream controller for an Enigma cipher core: input FIFO, sequencing FSM with
// per-character timeout, letter/bypass routing and a first-word-fall-through output FIFO.
module enigma_stream_ctrl #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       full,
  input  logic       start,
  input  logic       dec_in,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       empty,
  output logic       busy,
  output logic       error,
  output logic       core_valid,
  output logic [7:0] core_din,
  output logic       core_dec,
  input  logic [7:0] core_dout,
  input  logic       core_done
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StLoad = 3'd1;
  localparam logic [2:0] StSend = 3'd2;
  localparam logic [2:0] StWait = 3'd3;
  localparam logic [2:0] StPush = 3'd4;

  logic [7:0]  in_mem  [DEPTH];
  logic [7:0]  out_mem [DEPTH];

  logic [AW:0] in_wptr_q, in_wptr_d, in_rptr_q, in_rptr_d;
  logic [AW:0] out_wptr_q, out_wptr_d, out_rptr_q, out_rptr_d;
  logic [2:0]  state_q, state_d;
  logic [7:0]  char_q, char_d;
  logic [7:0]  res_q, res_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        dec_q, dec_d;
  logic        err_q, err_d;

  logic        in_full, in_empty, in_push, in_pop;
  logic        out_full, out_empty, out_push, out_pop;
  logic [7:0]  in_head;
  logic        is_letter;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign in_empty  = (in_wptr_q == in_rptr_q);
  assign in_full   = (in_wptr_q[AW] != in_rptr_q[AW]) &&
                     (in_wptr_q[AW-1:0] == in_rptr_q[AW-1:0]);
  assign out_empty = (out_wptr_q == out_rptr_q);
  assign out_full  = (out_wptr_q[AW] != out_rptr_q[AW]) &&
                     (out_wptr_q[AW-1:0] == out_rptr_q[AW-1:0]);

  assign in_head   = in_mem[in_rptr_q[AW-1:0]];
  assign is_letter = (in_head >= 8'h41) && (in_head <= 8'h5A);

  assign in_push  = wr_en & ~in_full;
  assign in_pop   = (state_q == StLoad) & ~in_empty;
  assign out_pop  = rd_en & ~out_empty;
  // A host pop in the same cycle frees the slot the stalled result needs.
  assign out_push = (state_q == StPush) & (~out_full | out_pop);

  always_comb begin
    in_wptr_d  = in_wptr_q;
    in_rptr_d  = in_rptr_q;
    out_wptr_d = out_wptr_q;
    out_rptr_d = out_rptr_q;
    if (in_push)  in_wptr_d  = in_wptr_q + (AW+1)'(1);
    if (in_pop)   in_rptr_d  = in_rptr_q + (AW+1)'(1);
    if (out_push) out_wptr_d = out_wptr_q + (AW+1)'(1);
    if (out_pop)  out_rptr_d = out_rptr_q + (AW+1)'(1);
  end

  always_comb begin
    state_d = state_q;
    char_d  = char_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    dec_d   = dec_q;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          dec_d   = dec_in;
          err_d   = 1'b0;
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (in_empty) begin
          state_d = StIdle;
        end else begin
          char_d = in_head;
          if (is_letter) begin
            state_d = StSend;
          end else begin
            res_d   = in_head;
            state_d = StPush;
          end
        end
      end
      StSend: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        if (core_done) begin
          res_d   = core_dout;
          state_d = StPush;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          res_d   = 8'h3F;
          state_d = StPush;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StPush: begin
        if (out_push) state_d = StLoad;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_wptr_q  <= '0;
      in_rptr_q  <= '0;
      out_wptr_q <= '0;
      out_rptr_q <= '0;
      state_q    <= StIdle;
      char_q     <= '0;
      res_q      <= '0;
      cnt_q      <= '0;
      dec_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      in_wptr_q  <= in_wptr_d;
      in_rptr_q  <= in_rptr_d;
      out_wptr_q <= out_wptr_d;
      out_rptr_q <= out_rptr_d;
      state_q    <= state_d;
      char_q     <= char_d;
      res_q      <= res_d;
      cnt_q      <= cnt_d;
      dec_q      <= dec_d;
      err_q      <= err_d;
    end
  end

  // Storage arrays need no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (in_push)  in_mem[in_wptr_q[AW-1:0]]   <= wr_data;
    if (out_push) out_mem[out_wptr_q[AW-1:0]] <= res_q;
  end

  assign full       = in_full;
  assign empty      = out_empty;
  assign rd_data    = out_empty ? 8'h00 : out_mem[out_rptr_q[AW-1:0]];
  assign busy       = (state_q != StIdle);
  assign error      = err_q;
  assign core_valid = (state_q == StSend);
  assign core_din   = char_q;
  assign core_dec   = dec_q;

endmodule

// File: tb/tb_enigma_stream_ctrl.sv
// Self-checking bench for enigma_stream_ctrl: directed scenarios plus randomized runs,
// with a stand-in cipher core and a byte-level queue model of the expected output stream.
module tb_enigma_stream_ctrl;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 8;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       wr_en, start, dec_in, rd_en;
  logic [7:0] wr_data;
  logic       full, empty, busy, error, core_valid, core_dec;
  logic [7:0] rd_data, core_din;
  logic [7:0] core_dout = 8'h00;
  logic       core_done = 1'b0;

  int n_cmp = 0;
  int n_fail = 0;
  int n_valid = 0;
  int core_lat = 5;
  bit core_mute = 0;
  int core_cnt = 0;
  bit core_pend = 0;

  logic [7:0] exp_q[$];
  int in_cnt;
  int let_cnt;
  bit run_dec, run_mute;
  int v0;

  enigma_stream_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .start     (start),
    .dec_in    (dec_in),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .empty     (empty),
    .busy      (busy),
    .error     (error),
    .core_valid(core_valid),
    .core_din  (core_din),
    .core_dec  (core_dec),
    .core_dout (core_dout),
    .core_done (core_done)
  );

  always #5 clk = ~clk;

  // Stand-in cipher core: answers core_lat cycles after a strobe, shifts by one letter.
  always @(negedge clk) begin
    core_done = 1'b0;
    if (core_pend) begin
      core_cnt = core_cnt - 1;
      if (core_cnt <= 0) begin
        core_pend = 0;
        if (!core_mute) begin
          core_done = 1'b1;
          core_dout = core_dec ? core_din - 8'd1 : core_din + 8'd1;
        end
      end
    end
    if (core_valid) begin
      core_pend = 1;
      core_cnt  = core_lat;
      n_valid   = n_valid + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_letter(input logic [7:0] b);
    return (b >= 8'h41) && (b <= 8'h5A);
  endfunction

  function automatic logic [7:0] exp_byte(input logic [7:0] b);
    if (!is_letter(b)) return b;
    if (run_mute) return 8'h3F;
    return run_dec ? b - 8'd1 : b + 8'd1;
  endfunction

  task automatic setup_run(input bit dec, input bit mute, input int lat);
    run_dec   = dec;
    run_mute  = mute;
    core_mute = mute;
    core_lat  = lat;
    in_cnt    = 0;
    let_cnt   = 0;
  endtask

  // Write while idle: the model alone decides whether the byte fits.
  task automatic wr_idle(input logic [7:0] b);
    if (in_cnt < DEPTH) begin
      exp_q.push_back(exp_byte(b));
      in_cnt++;
      if (is_letter(b)) let_cnt++;
    end
    wr_en = 1'b1;
    wr_data = b;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wr_busy(input logic [7:0] b);
    int w = 0;
    while (full && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("wr_room", full, 1'b0);
    if (!full) begin
      exp_q.push_back(exp_byte(b));
      if (is_letter(b)) let_cnt++;
      wr_en = 1'b1;
      wr_data = b;
      @(negedge clk);
      wr_en = 1'b0;
    end
  endtask

  task automatic pulse_start();
    v0 = n_valid;
    start = 1'b1;
    dec_in = run_dec;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int c = 0;
    while (busy && c < max_cyc) begin
      @(negedge clk);
      c++;
    end
    check("idle_reached", busy, 1'b0);
  endtask

  task automatic drain(input int max_cyc, input int rd_pct);
    int c = 0;
    while ((busy || !empty) && c < max_cyc) begin
      if (!empty && $urandom_range(99) < rd_pct) begin
        check("out_avail", (exp_q.size() > 0), 1'b1);
        if (exp_q.size() > 0) check("out_byte", rd_data, exp_q.pop_front());
        rd_en = 1'b1;
      end else begin
        rd_en = 1'b0;
      end
      @(negedge clk);
      c++;
    end
    rd_en = 1'b0;
    check("drain_busy", busy, 1'b0);
    check("drain_empty", empty, 1'b1);
    check("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    wr_en = 1'b0; wr_data = 8'h00; start = 1'b0; dec_in = 1'b0; rd_en = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_full", full, 1'b0);
    check("rst_empty", empty, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_valid", core_valid, 1'b0);
    check("rst_din", core_din, 8'h00);
    check("rst_dec", core_dec, 1'b0);
    check("rst_rd_data", rd_data, 8'h00);
    reset_n = 1'b1;
    @(negedge clk);

    // "ABC" through a +1 core with 5-cycle latency; check start-to-strobe timing.
    setup_run(0, 0, 5);
    wr_idle(8'h41); wr_idle(8'h42); wr_idle(8'h43);
    pulse_start();
    check("load_no_valid", core_valid, 1'b0);
    check("load_busy", busy, 1'b1);
    @(negedge clk);
    check("send_valid", core_valid, 1'b1);
    check("send_din", core_din, 8'h41);
    @(negedge clk);
    check("wait_no_valid", core_valid, 1'b0);
    wait_idle(300);
    check("abc_error", error, 1'b0);
    check("abc_strobes", n_valid - v0, 3);
    drain(100, 100);

    // "A B": the space bypasses the core.
    setup_run(0, 0, 3);
    wr_idle(8'h41); wr_idle(8'h20); wr_idle(8'h42);
    pulse_start();
    wait_idle(300);
    check("a_b_strobes", n_valid - v0, 2);
    drain(100, 100);

    // Overfill the input FIFO, then stall on a full output FIFO.
    setup_run(0, 0, 5);
    wr_idle(8'h45); wr_idle(8'h46); wr_idle(8'h47); wr_idle(8'h48);
    check("in_full", full, 1'b1);
    wr_idle(8'h49);
    check("in_full_drop", full, 1'b1);
    pulse_start();
    wr_busy(8'h4A); wr_busy(8'h4B); wr_busy(8'h4C);
    repeat (150) @(negedge clk);
    check("stall_busy", busy, 1'b1);
    check("stall_empty", empty, 1'b0);
    check("stall_strobes", n_valid - v0, 5);
    drain(600, 50);
    check("stall_total", n_valid - v0, let_cnt);

    // Silent core: each letter times out after TIMEOUT wait cycles.
    setup_run(0, 1, 5);
    wr_idle(8'h41); wr_idle(8'h42);
    pulse_start();
    @(negedge clk);
    check("to_valid", core_valid, 1'b1);
    repeat (TIMEOUT) @(negedge clk);
    check("to_err_early", error, 1'b0);
    @(negedge clk);
    check("to_err_set", error, 1'b1);
    wait_idle(300);
    check("to_strobes", n_valid - v0, 2);
    check("to_err_sticky", error, 1'b1);
    drain(100, 100);

    // Next accepted start clears the sticky error.
    setup_run(0, 0, 2);
    wr_idle(8'h4D);
    pulse_start();
    check("err_cleared", error, 1'b0);
    wait_idle(300);
    drain(100, 100);

    // Start while busy with the opposite mode is ignored.
    setup_run(1, 0, 4);
    wr_idle(8'h5A); wr_idle(8'h61); wr_idle(8'h42);
    pulse_start();
    repeat (2) @(negedge clk);
    start = 1'b1; dec_in = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("busy_start_dec", core_dec, 1'b1);
    wait_idle(300);
    check("busy_start_dec_end", core_dec, 1'b1);
    drain(100, 100);

    // Randomized runs.
    for (int it = 0; it < 10; it++) begin
      int n, extra;
      logic [7:0] b;
      setup_run(1'($urandom_range(1)), ($urandom_range(3) == 0), $urandom_range(7, 1));
      n = $urandom_range(5, 1);
      for (int k = 0; k < n; k++) begin
        if (k == 0 || $urandom_range(1) == 1) b = 8'h41 + 8'($urandom_range(25));
        else b = 8'($urandom_range(255));
        wr_idle(b);
      end
      pulse_start();
      extra = $urandom_range(2);
      for (int k = 0; k < extra; k++) wr_busy(8'($urandom_range(255)));
      drain(1000, 60);
      check("rnd_strobes", n_valid - v0, let_cnt);
      check("rnd_error", error, (run_mute && let_cnt > 0));
    end

    // Asynchronous reset in the middle of a WAIT.
    setup_run(1, 0, 6);
    wr_idle(8'h51);
    pulse_start();
    repeat (3) @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("ar_busy", busy, 1'b0);
    check("ar_valid", core_valid, 1'b0);
    check("ar_din", core_din, 8'h00);
    check("ar_dec", core_dec, 1'b0);
    check("ar_error", error, 1'b0);
    check("ar_empty", empty, 1'b1);
    check("ar_full", full, 1'b0);
    check("ar_rd_data", rd_data, 8'h00);
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    check("ar_post_busy", busy, 1'b0);
    check("ar_post_empty", empty, 1'b1);
    check("ar_post_rd_data", rd_data, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/enigma_stream_ctrl.md
ENIGMA_STREAM_CTRL -- requirements
Module: enigma_stream_ctrl

Interface
REQ-001 Parameter DEPTH, default 16, meaning entries in each of the input and output FIFOs (power of two, >=2).
REQ-002 Parameter TIMEOUT, default 255, meaning max cycles waited for core_done after a core_valid pulse.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 wr_en  input  1  host pushes wr_data into input FIFO.
REQ-006 wr_data  input  8  message byte (ASCII).
REQ-007 full  output  1  input FIFO holds DEPTH entries.
REQ-008 start  input  1  one-cycle pulse: begin draining input FIFO through the core.
REQ-009 dec_in  input  1  mode latched at start; 1 = decrypt.
REQ-010 rd_en  input  1  host pops output FIFO.
REQ-011 rd_data  output  8  head of output FIFO (valid when empty=0).
REQ-012 empty  output  1  output FIFO holds zero entries.
REQ-013 busy  output  1  FSM not in IDLE.
REQ-014 error  output  1  sticky; timeout occurred.
REQ-015 core_valid  output  1  one-cycle character strobe to the cipher core.
REQ-016 core_din  output  8  character to core, stable from core_valid until core_done.
REQ-017 core_dec  output  1  latched dec_in.
REQ-018 core_dout  input  8  core result, sampled when core_done=1.
REQ-019 core_done  input  1  core result strobe.

Function
REQ-020 Input FIFO: write when wr_en=1 and full=0; wr_en while full SHALL be dropped, contents unchanged.
REQ-021 Output FIFO: pop when rd_en=1 and empty=0; rd_en while empty SHALL be ignored; rd_data first-word-fall-through.
REQ-022 Pointers SHALL be log2(DEPTH)+1 bits, wrap modulo 2*DEPTH; full/empty from MSB compare; simultaneous push and pop on one FIFO SHALL keep count unchanged.
REQ-023 FSM states: IDLE, LOAD, SEND, WAIT, PUSH.
REQ-024 IDLE: start=1 -> latch dec_in into core_dec, go LOAD; start while busy=1 SHALL be ignored.
REQ-025 LOAD: input FIFO empty -> IDLE; else pop one byte into char register; byte in 0x41..0x5A -> SEND; any other byte -> PUSH with byte unchanged (bypass, core not used).
REQ-026 SEND: core_valid=1 for exactly one cycle, core_din=char register, clear timeout counter, go WAIT.
REQ-027 WAIT: core_done=1 -> capture core_dout into result register, go PUSH; core_done not sampled in any other state.
REQ-028 WAIT: counter reaches TIMEOUT without core_done -> set error, push 0x3F ('?'), go PUSH path; processing continues with next byte.
REQ-029 PUSH: output FIFO not full -> write result, go LOAD; full -> stay in PUSH (stall) until a host pop frees space; same-cycle pop and push while full SHALL succeed.
REQ-030 Per-letter latency start-to-core_valid: 2 cycles (IDLE->LOAD->SEND); core_done-to-output-write: 1 cycle.
REQ-031 Order: output FIFO bytes SHALL appear in input order, one output per input byte.
REQ-032 Host wr_en during busy=1 SHALL be accepted; bytes written before LOAD sees empty are processed in the same run.
REQ-033 error cleared only by reset or by the next accepted start.
REQ-034 core_valid SHALL never assert again until the prior character completed or timed out.

Reset
REQ-035 reset_n=0 at any time SHALL asynchronously force: FSM IDLE, both FIFOs empty (full=0, empty=1), core_valid=0, core_din=0, core_dec=0, busy=0, error=0, rd_data=0, counter 0; an in-flight character is discarded.

Verification
REQ-036 Write "ABC", start, model core returns din+1 after 5 cycles -> output FIFO "BCD", busy falls after last PUSH, error=0.
REQ-037 Write "A B", start -> core_valid pulses exactly twice; output byte 2 = 0x20 without core activity.
REQ-038 Write DEPTH+1 bytes with no reads -> full=1 after DEPTH, extra byte dropped; run with host not reading -> FSM stalls in PUSH, resumes on rd_en, no byte lost.
REQ-039 Core never returns done, TIMEOUT=8 -> after 8 WAIT cycles error=1, output 0x3F, next character still sent.
REQ-040 Assert reset_n=0 during WAIT -> all outputs at reset values immediately; later core_done ignored; empty=1.
REQ-041 start while busy, dec_in toggled -> ignored, core_dec keeps latched value.
